// File: rtl/ram_burst_pkg.sv
// Shared types and default widths for the scratch-RAM burst master.
package ram_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO that catches RAM read data arriving one cycle after each issue.
module rd_skid_fifo
    import ram_burst_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;

    always_ff @(posedge clk) begin
        if (clear) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the 16x8 scratch RAM: write bursts drain a stream into RAM, read bursts stream RAM out.
// Optional macro RAM_BURST_NOWRAP_EN: bursts crossing the top address are refused with a one-cycle err pulse.
module ram_burst_master
    import ram_burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
`ifdef RAM_BURST_NOWRAP_EN
    ,
    output logic              err
`endif
);

    // Every stream (cmd, wr, rd) transfers one item on a cycle where valid and ready are both high.
    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] issue_rem;
    logic [ADDR_W-1:0] pop_rem;
    logic              issue_fin;
    logic              inflight;
    logic              done_q;
    logic              done_next;
    logic              load;
    logic              beat;
    logic              issue;
    logic              pop;
    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;

`ifdef RAM_BURST_NOWRAP_EN
    logic              err_q;
    logic              err_next;
    logic [ADDR_W:0]   end_addr;

    assign end_addr = {1'b0, cmd_addr} + {1'b0, cmd_len};
    assign err      = err_q;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign rd_valid  = (fifo_count != 2'd0);
    assign pop       = rd_valid & rd_ready;
    // Entries held or still in flight after this cycle; capped at the skid depth.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        load       = 1'b0;
        beat       = 1'b0;
        issue      = 1'b0;
        wr_ready   = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
`ifdef RAM_BURST_NOWRAP_EN
        err_next   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
`ifdef RAM_BURST_NOWRAP_EN
                    if (end_addr[ADDR_W]) begin
                        err_next = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = cmd_we ? WRITE : READ;
                    end
`else
                    load       = 1'b1;
                    state_next = cmd_we ? WRITE : READ;
`endif
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                ram_addr = cur_addr;
                ram_din  = wr_data;
                ram_en   = wr_valid;
                ram_we   = wr_valid;
                beat     = wr_valid;
                if (beat && issue_rem == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            READ: begin
                ram_addr = cur_addr;
                issue    = !issue_fin && (occupancy < 3'd2);
                ram_en   = issue;
                if (pop && pop_rem == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            issue_rem <= '0;
            pop_rem   <= '0;
            issue_fin <= 1'b0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
`ifdef RAM_BURST_NOWRAP_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            done_q   <= done_next;
            inflight <= issue;
`ifdef RAM_BURST_NOWRAP_EN
            err_q    <= err_next;
`endif
            if (load) begin
                cur_addr  <= cmd_addr;
                issue_rem <= cmd_len;
                pop_rem   <= cmd_len;
                issue_fin <= 1'b0;
            end
            // Write beats and read issues share the address walk and issue countdown.
            if (beat || issue) begin
                cur_addr  <= cur_addr + ADDR_W'(1);
                issue_rem <= issue_rem - ADDR_W'(1);
                if (issue_rem == '0) begin
                    issue_fin <= 1'b1;
                end
            end
            if (pop) begin
                pop_rem <= pop_rem - ADDR_W'(1);
            end
        end
    end

    rd_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk   (clk),
        .clear (areset),
        .push  (inflight),
        .din   (ram_dout),
        .pop   (pop),
        .head  (rd_data),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed and randomized bench for ram_burst_master with a 16x8 RAM model and a burst-level reference model.
module tb_ram_burst_master;

    logic       clk;
    logic       areset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       ram_en;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
`ifdef RAM_BURST_NOWRAP_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int outstanding = 0;
    int prev_done = 0;

    // Reference model: memory image plus expected RAM accesses and read beats, in order.
    logic [7:0]  exp_mem [16] = '{default: 8'h00};
    logic [7:0]  ram     [16] = '{default: 8'h00};
    logic [11:0] exp_wr_q  [$];
    logic [3:0]  exp_iss_q [$];
    logic [7:0]  exp_rd_q  [$];
    logic [7:0]  wr_stim   [$];
    logic [11:0] mon_wr;
    logic [3:0]  mon_iss;
    logic [7:0]  mon_rd;

    ram_burst_master dut (
        .clk       (clk),
        .areset    (areset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
`ifdef RAM_BURST_NOWRAP_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_din;
            else        ram_dout <= ram[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every RAM access and every popped beat must match the model's next entry.
    always @(negedge clk) begin
        if (areset) begin
            outstanding = 0;
        end else begin
            if (ram_en && ram_we) begin
                check("wr_access_expected", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) begin
                    mon_wr = exp_wr_q.pop_front();
                    check("wr_access", 32'({ram_addr, ram_din}), 32'(mon_wr));
                end
            end
            if (ram_en && !ram_we) begin
                outstanding++;
                check("rd_issue_expected", 32'(exp_iss_q.size() != 0), 32'd1);
                if (exp_iss_q.size() != 0) begin
                    mon_iss = exp_iss_q.pop_front();
                    check("rd_issue_addr", 32'(ram_addr), 32'(mon_iss));
                end
            end
            if (rd_valid && rd_ready) begin
                outstanding--;
                check("rd_beat_expected", 32'(exp_rd_q.size() != 0), 32'd1);
                if (exp_rd_q.size() != 0) begin
                    mon_rd = exp_rd_q.pop_front();
                    check("rd_beat_data", 32'(rd_data), 32'(mon_rd));
                end
            end
            if (ram_en || (rd_valid && rd_ready))
                check("outstanding_le2", 32'(outstanding <= 2), 32'd1);
            if (done) done_cnt++;
        end
    end

    // base < 0 picks random write data; otherwise data is base, base+1, ...
    task automatic model_burst(input logic we, input logic [3:0] a, input logic [3:0] len, input int base);
        logic [3:0] ad;
        logic [7:0] d;
        for (int i = 0; i <= int'(len); i++) begin
            ad = a + 4'(i);
            if (we) begin
                d = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + i);
                exp_mem[ad] = d;
                exp_wr_q.push_back({ad, d});
                wr_stim.push_back(d);
            end else begin
                exp_iss_q.push_back(ad);
                exp_rd_q.push_back(exp_mem[ad]);
            end
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_cmd(input logic we, input logic [3:0] a, input logic [3:0] len);
        prev_done = done_cnt;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = len;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drive_writes(input int gap_pct, input int budget);
        logic acc;
        int   k;
        k = 0;
        while (wr_stim.size() != 0 && k < budget) begin
            wr_valid = ($urandom_range(0, 99) >= gap_pct);
            wr_data  = wr_stim[0];
            @(negedge clk);
            acc = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (acc) void'(wr_stim.pop_front());
            k++;
        end
        wr_valid = 1'b0;
        check("wr_stream_drained", 32'(wr_stim.size()), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        logic got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                check("done_busy_low", 32'(busy), 32'd0);
                check("done_cmd_ready", 32'(cmd_ready), 32'd1);
            end
            @(posedge clk); #1;
        end
        check("done_seen", 32'(got), 32'd1);
    endtask

    // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic run_read(input int mode, input int budget);
        logic got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (k % 3 == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                check("rd_done_busy_low", 32'(busy), 32'd0);
                check("rd_done_cmd_ready", 32'(cmd_ready), 32'd1);
            end
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        check("rd_done_seen", 32'(got), 32'd1);
    endtask

    task automatic burst_closed();
        check("exp_wr_drained", 32'(exp_wr_q.size()), 32'd0);
        check("exp_iss_drained", 32'(exp_iss_q.size()), 32'd0);
        check("exp_rd_drained", 32'(exp_rd_q.size()), 32'd0);
        check("done_once", 32'(done_cnt - prev_done), 32'd1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] len, input int base, input int gap_pct);
        model_burst(1'b1, a, len, base);
        send_cmd(1'b1, a, len);
        drive_writes(gap_pct, 200);
        wait_done(20);
        burst_closed();
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] len, input int mode);
        model_burst(1'b0, a, len, -1);
        send_cmd(1'b0, a, len);
        run_read(mode, 200);
        burst_closed();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a;
        logic [3:0] len;
        int         pops;
        int         keep;

        areset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk); #1;
        areset = 1'b0;

        // Single-beat write at address 3.
        model_burst(1'b1, 4'd3, 4'd0, 8'hA5);
        send_cmd(1'b1, 4'd3, 4'd0);
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        check("w1_ram_en", 32'(ram_en), 32'd1);
        check("w1_ram_we", 32'(ram_we), 32'd1);
        check("w1_ram_addr", 32'(ram_addr), 32'd3);
        check("w1_ram_din", 32'(ram_din), 32'hA5);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        void'(wr_stim.pop_front());
        @(negedge clk);
        check("w1_done", 32'(done), 32'd1);
        check("w1_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("w1_done_pulse", 32'(done), 32'd0);
        @(posedge clk); #1;
        burst_closed();
        check("w1_ram3", 32'(ram[3]), 32'hA5);

        // Four-beat write with valid gaps.
        do_write(4'd0, 4'd3, 8'h10, 40);
        check("wb_ram0", 32'(ram[0]), 32'h10);
        check("wb_ram3", 32'(ram[3]), 32'h13);

        // Read back 0..3 with rd_ready held: two-cycle latency, then one beat per cycle.
        rd_ready = 1'b1;
        model_burst(1'b0, 4'd0, 4'd3, -1);
        send_cmd(1'b0, 4'd0, 4'd3);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("rb_rd_valid", 32'(rd_valid), 32'((k >= 2) && (k <= 5)));
            check("rb_done", 32'(done), 32'(k == 6));
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        burst_closed();

        // Backpressure 1,0,0 and random readiness.
        do_write(4'd5, 4'd9, -1, 20);
        do_read(4'd5, 4'd9, 1);
        do_read(4'd2, 4'd12, 2);

        // Burst crossing the top address.
`ifdef RAM_BURST_NOWRAP_EN
        send_cmd(1'b1, 4'd14, 4'd3);
        @(negedge clk);
        check("nw_err", 32'(err), 32'd1);
        check("nw_busy", 32'(busy), 32'd0);
        check("nw_ram_en", 32'(ram_en), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("nw_err_pulse", 32'(err), 32'd0);
        check("nw_no_done", 32'(done_cnt - prev_done), 32'd0);
        @(posedge clk); #1;
`else
        do_write(4'd14, 4'd3, 8'hC0, 10);
        check("wrap_ram15", 32'(ram[15]), 32'hC1);
        check("wrap_ram0", 32'(ram[0]), 32'hC2);
        do_read(4'd14, 4'd3, 0);
`endif

        // Reset in the middle of a read burst, after two beats.
        rd_ready = 1'b1;
        model_burst(1'b0, 4'd0, 4'd7, -1);
        send_cmd(1'b0, 4'd0, 4'd7);
        pops = 0;
        for (int k = 0; k < 50 && pops < 2; k++) begin
            @(negedge clk);
            if (rd_valid && rd_ready) pops++;
            @(posedge clk); #1;
        end
        check("mr_two_pops", 32'(pops), 32'd2);
        keep = done_cnt;
        areset = 1'b1; rd_ready = 1'b0;
        exp_wr_q.delete(); exp_iss_q.delete(); exp_rd_q.delete(); wr_stim.delete();
        @(posedge clk); #1;
        areset = 1'b0;
        @(negedge clk);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_rd_valid", 32'(rd_valid), 32'd0);
        check("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mr_done", 32'(done), 32'd0);
        check("mr_ram_en", 32'(ram_en), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mr_no_done", 32'(done_cnt - keep), 32'd0);
        do_read(4'd0, 4'd3, 0);

        // Randomized bursts against the reference model.
        for (int n = 0; n < 24; n++) begin
            a   = 4'($urandom_range(0, 15));
            len = 4'($urandom_range(0, 15));
`ifdef RAM_BURST_NOWRAP_EN
            if (int'(a) + int'(len) > 15) len = 4'd15 - a;
`endif
            if ($urandom_range(0, 1) == 1) do_write(a, len, -1, $urandom_range(0, 60));
            else                           do_read(a, len, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
